// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Default clock rate, counter width and common terminal counts for typical rates.
package tick_gen_pkg;

  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_CNT_W  = 27;

  localparam int TC_1HZ  = DEF_CLK_HZ - 1;
  localparam int TC_60HZ = DEF_CLK_HZ / 60 - 1;
  localparam int TC_4HZ  = DEF_CLK_HZ / 4 - 1;

  // Select width for a channel index, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: a free-running counter with an active and a shadow terminal count.
// A new terminal count is staged in the shadow and swapped in only at a period boundary.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEFAULT_TC = TC_1HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] val,
  output logic             tick,
  output logic             level,
  output logic             pend
);

  localparam logic [CNT_W-1:0] TC_RST = CNT_W'(DEFAULT_TC);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tc;
  logic [CNT_W-1:0] r_sh;
  logic             r_pend;
  logic             r_tick;
  logic             r_level;

  logic w_term;
  logic w_apply;

  // cnt above tc can only follow a tc change while disabled; treat it as terminal.
  assign w_term  = en && (r_cnt >= r_tc);
  // A staged count is applied at a boundary, or at once when the channel is idle.
  assign w_apply = r_pend && (!en || w_term);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_tc    <= TC_RST;
      r_sh    <= '0;
      r_pend  <= 1'b0;
      r_tick  <= 1'b0;
      r_level <= 1'b0;
    end else if (sync) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_level <= 1'b0;
      r_pend  <= 1'b0;
      if (we) begin
        r_tc <= val;
      end else if (r_pend) begin
        r_tc <= r_sh;
      end
    end else begin
      if (w_term) begin
        r_cnt   <= '0;
        r_tick  <= 1'b1;
        r_level <= ~r_level;
      end else if (en) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end else begin
        r_tick <= 1'b0;
      end

      if (w_apply) begin
        r_tc   <= r_sh;
        r_pend <= 1'b0;
      end

      // A write in the same cycle as an apply stages behind it.
      if (we) begin
        r_sh   <= val;
        r_pend <= 1'b1;
      end
    end
  end

  assign tick  = r_tick;
  assign level = r_level;
  assign pend  = r_pend;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel runtime-programmable tick generator.
// Decodes the shared terminal-count write bus and instantiates one tick_chan per channel.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int NCH        = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEFAULT_TC = CLK_HZ - 1,
  parameter int SEL_W      = clog2_min1(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             tc_we,
  input  logic [SEL_W-1:0] tc_sel,
  input  logic [CNT_W-1:0] tc_val,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] w_we;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      // Selects at or above NCH match no channel and are dropped.
      assign w_we[gi] = tc_we && (tc_sel == SEL_W'(gi));

      tick_chan #(
        .CNT_W      (CNT_W),
        .DEFAULT_TC (DEFAULT_TC)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .en    (en[gi]),
        .sync  (sync),
        .we    (w_we[gi]),
        .val   (tc_val),
        .tick  (tick[gi]),
        .level (level[gi]),
        .pend  (pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi with CLK_HZ=100, NCH=4, CNT_W=8, DEFAULT_TC=99.
module tb_tick_gen_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic       sync;
  logic       tc_we;
  logic [1:0] tc_sel;
  logic [7:0] tc_val;
  logic [3:0] tick;
  logic [3:0] level;
  logic [3:0] pend;

  int checks = 0;
  int errors = 0;

  tick_gen_multi #(
    .CLK_HZ     (100),
    .NCH        (4),
    .CNT_W      (8),
    .DEFAULT_TC (99)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .tc_we  (tc_we),
    .tc_sel (tc_sel),
    .tc_val (tc_val),
    .tick   (tick),
    .level  (level),
    .pend   (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic       sy;
    logic       we;
    logic [1:0] sel;
    logic [7:0] val;
    logic [3:0] tk;
    logic [3:0] lv;
    logic [3:0] pd;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic [3:0] e, input logic s, input logic w,
                              input logic [1:0] sl, input logic [7:0] v,
                              input logic [3:0] tk, input logic [3:0] lv, input logic [3:0] pd);
    vec_t r;
    r.en = e; r.sy = s; r.we = w; r.sel = sl; r.val = v;
    r.tk = tk; r.lv = lv; r.pd = pd;
    return r;
  endfunction

  task automatic step(input logic rst, input logic [3:0] e, input logic s, input logic w,
                      input logic [1:0] sl, input logic [7:0] v);
    @(negedge clk);
    reset = rst; en = e; sync = s; tc_we = w; tc_sel = sl; tc_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] et, input logic [3:0] el, input logic [3:0] ep);
    checks++;
    if (tick !== et || level !== el || pend !== ep) begin
      errors++;
      $display("FAIL %s[%0d] got tick=%b level=%b pend=%b want tick=%b level=%b pend=%b",
               name, idx, tick, level, pend, et, el, ep);
    end
  endtask

  initial begin
    // Reprogramming channel 1 while idle, then mid-period and at terminal count.
    tbl[0]  = mk(4'b0000, 0, 1, 2'd1, 8'd3, 4'b0000, 4'b0000, 4'b0010);
    tbl[1]  = mk(4'b0000, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    tbl[5]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    tbl[6]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[7]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[8]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[9]  = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0000, 4'b0000);
    tbl[10] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    tbl[11] = mk(4'b0010, 0, 1, 2'd1, 8'd1, 4'b0000, 4'b0000, 4'b0010);
    tbl[12] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010);
    tbl[13] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    tbl[14] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[15] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0000, 4'b0000);
    tbl[16] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000);
    tbl[17] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    tbl[18] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[19] = mk(4'b0010, 0, 1, 2'd1, 8'd5, 4'b0010, 4'b0000, 4'b0010);
    tbl[20] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0000, 4'b0010);
    tbl[21] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0010, 4'b0000);
    tbl[22] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[23] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[24] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[25] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[26] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0000, 4'b0010, 4'b0000);
    tbl[27] = mk(4'b0010, 0, 0, 2'd0, 8'd0, 4'b0010, 4'b0000, 4'b0000);

    reset = 1'b1; en = '0; sync = 1'b0; tc_we = 1'b0; tc_sel = '0; tc_val = '0;

    // Reset state.
    step(1, 4'b0000, 0, 0, 2'd0, 8'd0);
    step(1, 4'b0000, 0, 0, 2'd0, 8'd0);
    check("reset", 0, 4'b0000, 4'b0000, 4'b0000);

    // Default 100-cycle period on channel 0.
    for (int c = 1; c <= 250; c++) begin
      step(0, 4'b0001, 0, 0, 2'd0, 8'd0);
      check("default_rate", c, (c == 100 || c == 200) ? 4'b0001 : 4'b0000,
            (c >= 100 && c < 200) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    for (int i = 0; i < 28; i++) begin
      step(0, tbl[i].en, tbl[i].sy, tbl[i].we, tbl[i].sel, tbl[i].val);
      check("table", i, tbl[i].tk, tbl[i].lv, tbl[i].pd);
      $display("vec %0d en=%b we=%b sel=%0d val=%0d -> tick=%b level=%b pend=%b",
               i, tbl[i].en, tbl[i].we, tbl[i].sel, tbl[i].val, tick, level, pend);
    end

    // Stage ch0=9 and ch2=4, then sync with a direct write of ch3=2.
    step(0, 4'b0000, 0, 1, 2'd0, 8'd9);
    check("stage_ch0", 0, 4'b0000, 4'b0000, 4'b0001);
    step(0, 4'b0000, 0, 1, 2'd2, 8'd4);
    check("stage_ch2", 0, 4'b0000, 4'b0000, 4'b0100);
    step(0, 4'b1101, 1, 1, 2'd3, 8'd2);
    check("sync", 0, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 1; c <= 27; c++) begin
      logic [3:0] et, el;
      et = {(c % 3 == 0), (c % 5 == 0), 1'b0, (c % 10 == 0)};
      el = {((c / 3) % 2 == 1), ((c / 5) % 2 == 1), 1'b0, ((c / 10) % 2 == 1)};
      step(0, 4'b1101, 0, 0, 2'd0, 8'd0);
      check("after_sync", c, et, el, 4'b0000);
    end

    // Shrink ch0 to 3 while disabled with cnt=7: wraps on the first enabled edge.
    step(0, 4'b0000, 0, 1, 2'd0, 8'd3);
    check("shrink_stage", 0, 4'b0000, 4'b1100, 4'b0001);
    step(0, 4'b0000, 0, 0, 2'd0, 8'd0);
    check("shrink_apply", 0, 4'b0000, 4'b1100, 4'b0000);
    for (int k = 1; k <= 5; k++) begin
      step(0, 4'b0001, 0, 0, 2'd0, 8'd0);
      check("cnt_over_tc", k, (k == 1 || k == 5) ? 4'b0001 : 4'b0000,
            (k < 5) ? 4'b1101 : 4'b1100, 4'b0000);
    end

    // tc=0 on ch1: tick every cycle.
    step(0, 4'b0000, 0, 1, 2'd1, 8'd0);
    check("tc0_stage", 0, 4'b0000, 4'b1100, 4'b0010);
    step(0, 4'b0000, 0, 0, 2'd0, 8'd0);
    check("tc0_apply", 0, 4'b0000, 4'b1100, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      step(0, 4'b0010, 0, 0, 2'd0, 8'd0);
      check("tc0_run", k, 4'b0010, (k % 2 == 1) ? 4'b1110 : 4'b1100, 4'b0000);
    end

    // Reset mid-period with a pending load on ch3 and a concurrent write.
    step(0, 4'b1001, 0, 1, 2'd3, 8'd7);
    check("pend_ch3", 0, 4'b0000, 4'b1100, 4'b1000);
    step(1, 4'b1001, 0, 1, 2'd3, 8'd1);
    check("reset_mid", 0, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 1; c <= 101; c++) begin
      step(0, 4'b1111, 0, 0, 2'd0, 8'd0);
      check("post_reset", c, (c == 100) ? 4'b1111 : 4'b0000,
            (c >= 100) ? 4'b1111 : 4'b0000, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Multi-channel, runtime-programmable tick generator. Successor to the single-rate, fixed-divisor tick block.
- Each of NCH channels has:
  - its own terminal count;
  - an enable;
  - a glitch-free shadow-load mechanism;
  - a one-cycle tick output and a toggling level output.
- Sits between the system clock and game/display logic that needs several independent rates, e.g. 1 Hz timer, 4 Hz blink, 60 Hz refresh.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; used only for the default.
- NCH, 4, number of channels (1..16).
- CNT_W, 27, counter and terminal-count width; must satisfy 2**CNT_W > CLK_HZ.
- DEFAULT_TC, CLK_HZ-1, terminal count loaded into every channel at reset (1 Hz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  NCH  per-channel count enable
- sync  in  1  restart all channel counters together (phase alignment)
- tc_we  in  1  terminal-count write strobe
- tc_sel  in  $clog2(NCH) (min 1)  channel addressed by tc_we
- tc_val  in  CNT_W  new terminal count; period = tc_val+1 cycles
- tick  out  NCH  one-cycle pulse per period, per channel
- level  out  NCH  toggles on each tick; square wave of period 2*(tc+1)
- pend  out  NCH  1 = shadow terminal count waiting to be applied

Behaviour:
- Per-channel state:
  - cnt [CNT_W]
  - tc [CNT_W] (active)
  - sh [CNT_W] (shadow)
  - pend, tick, level
- All outputs are registered.
- Reset, synchronous:
  - cnt=0, tc=DEFAULT_TC, sh=0, pend=0, tick=0, level=0 on all channels.
  - Reset overrides every other input in the same cycle.
- Counting, per clock edge, for each channel with en=1:
  - If cnt==tc: cnt<=0, tick<=1, level<=~level, and if pend then tc<=sh, pend<=0.
  - Else: cnt<=cnt+1, tick<=0.
  - tc=0 gives tick high every cycle and level toggling every cycle.
- Latency from reset release with en=1 and tc=N-1:
  - First tick is high in cycle N after the first active edge.
  - Subsequent ticks follow every N cycles exactly.
- Disabled channel (en=0):
  - cnt and level hold, tick<=0.
  - A pending load is applied immediately: tc<=sh, pend<=0.
  - Re-enable resumes from the held cnt.
- Write (tc_we=1):
  - sh[tc_sel]<=tc_val, pend[tc_sel]<=1.
  - Last write wins if pend is already set.
  - tc_sel>=NCH is ignored.
  - Active tc never changes mid-period, so no runt or stretched periods.
- Write in the same cycle as the channel's terminal count:
  - The old sh is applied to tc (if pend was set).
  - The new value lands in sh with pend=1 and applies at the next terminal count.
- sync=1, all channels regardless of en:
  - cnt<=0, tick<=0, level<=0.
  - Pending loads are applied: tc<=sh, pend<=0.
  - A tc_we in the same cycle is written straight to tc of the selected channel, with pend left 0.
  - sync has priority over counting.
- If cnt>tc, which can only occur through a tc change while disabled, treat it as terminal: wrap to 0 with a tick on the next enabled edge. Use the comparison cnt>=tc.
- Channels are fully independent except for sync and the shared write bus.

Decomposition:
- Shared package tick_gen_pkg:
  - CNT_W default
  - function clog2_min1
  - localparam TC_1HZ = CLK_HZ-1
  - localparam TC_60HZ = CLK_HZ/60-1
  - localparam TC_4HZ = CLK_HZ/4-1
- Sub-module tick_chan holds one channel's cnt/tc/sh/pend/tick/level. Ports:
  - clk, reset, en, sync, we (already decoded), val, tick, level, pend.
- Top-level tick_gen_multi contains the write-select decode and a generate loop of NCH tick_chan instances.

Test Plan:
- Setup: parameters CLK_HZ=100, NCH=4, CNT_W=8, DEFAULT_TC=99.
- Reset then en=4'b0001 for 250 cycles -> tick[0] high in cycles 100 and 200 only; level[0] 0→1 at 100, →0 at 200; other channels tick=0, level=0.
- Write tc_sel=1, tc_val=3 while disabled; enable ch1 -> pend[1] drops the cycle after the write; tick[1] every 4 cycles, first in cycle 4 after enable.
- Ch1 running tc=3, write tc_val=1 at cnt=1 -> pend[1]=1; next tick after 4 cycles total from the previous tick; then ticks every 2 cycles; pend[1] clears on that tick edge.
- Write exactly at cnt==tc with tc_val=5 -> that tick keeps the old period; new period 6 starts after the following tick; pend visible for one full period.
- Ch0 tc=9, ch2 tc=4, both running, assert sync 1 cycle -> cnt=0, level=0 both; ch2 ticks 5 and 10 cycles later, ch0 at 10 cycles, coincident.
- Assert reset mid-period with pend set on ch3 and tc_we=1 asserted in the same cycle -> all outputs 0, tc=99 everywhere, pend=0, the write is dropped.
